// File: rtl/bicubic_norm_pkg.sv
// Shared constants and helpers for the bicubic normalisation arbiter slice.
package bicubic_norm_pkg;

  localparam int unsigned A_W            = 40;
  localparam int unsigned B_W            = 38;
  localparam int unsigned RES_W          = 9;
  localparam int unsigned DP_LAT_DEFAULT = 7;

  localparam logic [RES_W-1:0] COEFF_HALF_DEFAULT = 9'd128;

  // Tag width for n requesters; never narrower than one bit.
  function automatic int unsigned tag_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: grants the first request at or after the pointer.
module rr_arbiter
  import bicubic_norm_pkg::*;
#(
  parameter int unsigned N  = 3,
  localparam int unsigned TW = tag_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [TW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [TW-1:0] ptr_q, ptr_d;
  logic          found;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned idx;
      idx = 32'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx[TW-1:0];
      end
    end
  end

  always_comb begin
    gnt     = '0;
    gnt_vld = en & found;
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  // Every grant is a transfer (gnt only asserts on a valid request).
  always_comb begin
    int unsigned nxt;
    nxt   = 32'(gnt_idx) + 1;
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (nxt == N) ? '0 : nxt[TW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bicubic_norm_arbiter.sv
// Shares one bicubic normalisation datapath among N requesters and steers results back.
// Optional perf counters are enabled by defining BICUBIC_NORM_ARB_PERF_EN.
module bicubic_norm_arbiter
  import bicubic_norm_pkg::*;
#(
  parameter int unsigned N      = 3,
  parameter int unsigned DP_LAT = bicubic_norm_pkg::DP_LAT_DEFAULT,
  parameter int unsigned A_W    = bicubic_norm_pkg::A_W,
  parameter int unsigned B_W    = bicubic_norm_pkg::B_W,
  localparam int unsigned TW    = tag_w(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_en,
  input  logic [RES_W-1:0]   cfg_coeff_half,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [N*A_W-1:0]   req_a,
  input  logic [N*B_W-1:0]   req_b,
  input  logic [N-1:0]       req_c,
  output logic [A_W-1:0]     dp_a,
  output logic [B_W-1:0]     dp_b,
  output logic               dp_c,
  output logic [RES_W-1:0]   dp_coeff_half,
  input  logic [RES_W-1:0]   dp_result,
  output logic [N-1:0]       rsp_valid,
  output logic [RES_W-1:0]   rsp_data,
  output logic               busy
`ifdef BICUBIC_NORM_ARB_PERF_EN
  ,
  output logic [N*16-1:0]    perf_grant_cnt,
  output logic [15:0]        perf_stall_cnt
`endif
);

  logic [TW-1:0] gnt_idx;
  logic          xfer;

  rr_arbiter #(
    .N (N)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (cfg_en),
    .req     (req_valid),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx),
    .gnt_vld (xfer)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_a          <= '0;
      dp_b          <= '0;
      dp_c          <= 1'b0;
      dp_coeff_half <= '0;
    end else if (xfer) begin
      dp_a          <= req_a[gnt_idx*A_W +: A_W];
      dp_b          <= req_b[gnt_idx*B_W +: B_W];
      dp_c          <= req_c[gnt_idx];
      dp_coeff_half <= cfg_coeff_half;
    end
  end

  // Index 0 sits alongside the dp_* operand registers; index DP_LAT lines up with dp_result.
  logic [DP_LAT:0] vld_q;
  logic [TW-1:0]   tag_q [DP_LAT+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i <= DP_LAT; i++) tag_q[i] <= '0;
    end else begin
      vld_q    <= {vld_q[DP_LAT-1:0], xfer};
      tag_q[0] <= gnt_idx;
      for (int unsigned i = 1; i <= DP_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // dp_result comes from unreset datapath registers; only the tail valid qualifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= vld_q[DP_LAT] ? (N'(1) << tag_q[DP_LAT]) : '0;
      if (vld_q[DP_LAT]) rsp_data <= dp_result;
    end
  end

  assign busy = (|vld_q) | (|rsp_valid);

`ifdef BICUBIC_NORM_ARB_PERF_EN
  logic [15:0] grant_cnt_q [N];
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) grant_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (xfer && grant_cnt_q[gnt_idx] != 16'hFFFF) begin
        grant_cnt_q[gnt_idx] <= grant_cnt_q[gnt_idx] + 16'd1;
      end
      if ((|req_valid) && !xfer && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    perf_grant_cnt = '0;
    for (int unsigned i = 0; i < N; i++) perf_grant_cnt[i*16 +: 16] = grant_cnt_q[i];
  end

  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bicubic_norm_arbiter.sv
// Scoreboard bench for bicubic_norm_arbiter with a behavioural datapath stub.
module tb_bicubic_norm_arbiter;

  localparam int N      = 3;
  localparam int DP_LAT = 7;
  localparam int A_W    = 40;
  localparam int B_W    = 38;
  localparam int RSP_LAT = DP_LAT + 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_en;
  logic [8:0]         cfg_coeff_half;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*A_W-1:0]   req_a;
  logic [N*B_W-1:0]   req_b;
  logic [N-1:0]       req_c;
  logic [A_W-1:0]     dp_a;
  logic [B_W-1:0]     dp_b;
  logic               dp_c;
  logic [8:0]         dp_coeff_half;
  logic [8:0]         dp_result;
  logic [N-1:0]       rsp_valid;
  logic [8:0]         rsp_data;
  logic               busy;
`ifdef BICUBIC_NORM_ARB_PERF_EN
  logic [N*16-1:0]    perf_grant_cnt;
  logic [15:0]        perf_stall_cnt;
`endif

  bicubic_norm_arbiter #(
    .N      (N),
    .DP_LAT (DP_LAT),
    .A_W    (A_W),
    .B_W    (B_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_en         (cfg_en),
    .cfg_coeff_half (cfg_coeff_half),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_c          (req_c),
    .dp_a           (dp_a),
    .dp_b           (dp_b),
    .dp_c           (dp_c),
    .dp_coeff_half  (dp_coeff_half),
    .dp_result      (dp_result),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .busy           (busy)
`ifdef BICUBIC_NORM_ARB_PERF_EN
    ,
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Normalise (a - b + c*2^32 + coeff_half*2^16) >> 24, clamped to [0, 511].
  function automatic logic [8:0] norm_ref(logic [A_W-1:0] a, logic [B_W-1:0] b, logic c,
                                          logic [8:0] h);
    longint s;
    s = longint'(a) - longint'(b) + (longint'(c) << 32) + (longint'(h) << 16);
    if (s < 0) return 9'd0;
    s = s >>> 24;
    if (s > 511) return 9'd511;
    return s[8:0];
  endfunction

  // Datapath stub: captures dp_* each edge, result emerges DP_LAT edges later.
  logic [8:0] dp_pipe [DP_LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= norm_ref(dp_a, dp_b, dp_c, dp_coeff_half);
    for (int i = 1; i < DP_LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_result = dp_pipe[DP_LAT-1];

  typedef struct {
    int         tag;
    logic [8:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mptr = 0;
  int   rsp_cnt = 0;
  int   last_rsp_cyc = -1;
  bit   busy_hist [int];
  int   m_grant [N];
  int   m_stall = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever a response pulse appears.
  always @(negedge clk) begin
    if (rst_n) begin
      busy_hist[cyc] = busy;
      if (rsp_valid != '0) begin
        rsp_cnt++;
        last_rsp_cyc = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_rsp", longint'(rsp_valid), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_tag", longint'(rsp_valid), longint'(1) << e.tag);
          chk("rsp_data", longint'(rsp_data), longint'(e.data));
          chk("rsp_latency", longint'(cyc - e.cyc), RSP_LAT);
        end
      end
    end
  end

  // One clock of stimulus: model the grant, check ready, log expectations.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    int g;
    exp_t e;
    @(negedge clk);
    exp_rdy = '0;
    g = -1;
    if (cfg_en) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mptr + k) % N;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", longint'(req_ready), longint'(exp_rdy));
    if (g >= 0) begin
      e.tag  = g;
      e.data = norm_ref(req_a[g*A_W +: A_W], req_b[g*B_W +: B_W], req_c[g], cfg_coeff_half);
      e.cyc  = cyc;
      sb.push_back(e);
      grant_log.push_back(g);
      mptr = (g + 1) % N;
      if (m_grant[g] < 16'hFFFF) m_grant[g]++;
    end else if (req_valid != '0) begin
      if (m_stall < 16'hFFFF) m_stall++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", longint'(sb.size()), 0);
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*A_W +: A_W] = A_W'({$urandom_range(0, 511), $urandom()});
      req_b[i*B_W +: B_W] = B_W'({$urandom_range(0, 255), $urandom()});
      req_c[i]            = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic model_reset();
    sb.delete();
    mptr = 0;
    m_stall = 0;
    for (int i = 0; i < N; i++) m_grant[i] = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    cfg_en = 1'b1;
    cfg_coeff_half = 9'd128;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", longint'(req_ready), 0);
    chk("rst_rsp_valid", longint'(rsp_valid), 0);
    chk("rst_rsp_data", longint'(rsp_data), 0);
    chk("rst_dp_a", longint'(dp_a), 0);
    chk("rst_dp_b", longint'(dp_b), 0);
    chk("rst_dp_c", longint'(dp_c), 0);
    chk("rst_dp_coeff", longint'(dp_coeff_half), 0);
    chk("rst_busy", longint'(busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();

    // Single op from requester 0.
    req_a[0 +: A_W] = 40'h0040000000;
    req_valid = 3'b001;
    cycle();
    req_valid = '0;
    wait_empty(RSP_LAT + 4);
    chk("single_data", longint'(rsp_data), 64);

    // Clamp to zero then carry, on consecutive cycles.
    req_b[1*B_W +: B_W] = B_W'(1);
    req_c[2] = 1'b1;
    req_valid = 3'b110;
    cycle();
    req_valid = 3'b100;
    cycle();
    req_valid = '0;
    wait_empty(RSP_LAT + 4);
    chk("carry_data", longint'(rsp_data), 256);
    chk("clamp_carry_back_to_back", longint'(busy_hist.exists(last_rsp_cyc - 1) ?
        busy_hist[last_rsp_cyc - 1] : 1'b0), 1);

    // Fairness: all requesters held valid for 9 cycles.
    grant_log.delete();
    req_valid = '1;
    for (int i = 0; i < 9; i++) begin
      randomize_ops();
      cycle();
    end
    req_valid = '0;
    chk("fair_grant_count", longint'(grant_log.size()), 9);
    for (int i = 0; i < 9 && i < grant_log.size(); i++) begin
      chk("fair_order", longint'(grant_log[i]), longint'(i % N));
    end
    wait_empty(RSP_LAT + 4);

    // Drain: 4 accepts, then cfg_en drops with requests still pending.
    req_valid = '1;
    for (int i = 0; i < 4; i++) begin
      randomize_ops();
      cycle();
    end
    cfg_en = 1'b0;
    wait_empty(RSP_LAT + 6);
    cycle();
    cycle();
    chk("drain_busy_at_last", longint'(busy_hist[last_rsp_cyc]), 1);
    chk("drain_busy_after", longint'(busy_hist[last_rsp_cyc + 1]), 0);
    req_valid = '0;
    cfg_en = 1'b1;

    // Reset mid-flight discards in-flight operations.
    req_valid = '1;
    for (int i = 0; i < 3; i++) begin
      randomize_ops();
      cycle();
    end
    req_valid = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_cnt = 0;
    repeat (RSP_LAT + 3) cycle();
    chk("no_stale_rsp", longint'(rsp_cnt), 0);
    randomize_ops();
    req_valid = 3'b010;
    cycle();
    req_valid = '0;
    wait_empty(RSP_LAT + 4);
    chk("post_reset_rsp_count", longint'(rsp_cnt), 1);

    // Randomised traffic with cfg_en and coefficient changes.
    for (int i = 0; i < 300; i++) begin
      randomize_ops();
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      cfg_en = ($urandom_range(0, 9) != 0);
      cfg_coeff_half = 9'($urandom());
      cycle();
    end
    req_valid = '0;
    cfg_en = 1'b1;
    wait_empty(RSP_LAT + 6);
    chk("idle_busy", longint'(busy), 0);

`ifdef BICUBIC_NORM_ARB_PERF_EN
    chk("perf_stall", longint'(perf_stall_cnt), longint'(m_stall));
    for (int i = 0; i < N; i++) begin
      chk("perf_grant", longint'(perf_grant_cnt[i*16 +: 16]), longint'(m_grant[i]));
    end
    cfg_en = 1'b0;
    req_valid = 3'b001;
    repeat (5) cycle();
    chk("perf_stall_cfg_off", longint'(perf_stall_cnt), longint'(m_stall));
    cfg_en = 1'b1;
    for (int i = 0; i < 70000; i++) cycle();
    req_valid = '0;
    wait_empty(RSP_LAT + 6);
    chk("perf_grant_sat", longint'(perf_grant_cnt[15:0]), 16'hFFFF);
    chk("perf_grant_model", longint'(perf_grant_cnt[15:0]), longint'(m_grant[0]));
`endif

    chk("sb_empty", longint'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
